alu_issue_ctrl: RTL and testbench

- Execute-stage sequencer that sits directly upstream of alu_32.
- Accepts decoded ID/EX operands with a valid/ready handshake and translates MIPS alu_op/funct into the 5-bit ALU control code.
- Fires the ALU's edge-triggered start, waits for completion or an error, and presents a registered, exception-tagged result to EX/MEM with a valid/ready handshake.

---
 rtl/alu_issue_ctrl.sv | 155 +++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Execute-stage sequencer in front of alu_32: decodes alu_op/funct, fires one start pulse,
// waits for completion/error/timeout and holds an exception-tagged result for EX/MEM.
module alu_issue_ctrl #(
  parameter int unsigned TAG_W   = 5,
  parameter int unsigned TIMEOUT = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [1:0]       in_alu_op,
  input  logic [5:0]       in_funct,
  input  logic [TAG_W-1:0] in_tag,
  output logic             alu_start,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [4:0]       alu_control,
  input  logic             alu_finished,
  input  logic [31:0]      alu_result,
  input  logic             alu_zero,
  input  logic             alu_cout,
  input  logic             alu_err_overflow,
  input  logic             alu_err_invalid,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic             out_zero,
  output logic             out_cout,
  output logic             out_exc_overflow,
  output logic             out_exc_invalid,
  output logic             out_exc_timeout,
  output logic [TAG_W-1:0] out_tag
);

  typedef enum logic [2:0] {StIdle, StSetup, StFire, StWait, StDone} state_e;

  localparam logic [3:0] TimeoutCnt = 4'(TIMEOUT);
  localparam logic [4:0] CtrlInvalid = 5'h1F;

  state_e           state_q;
  logic [3:0]       cnt_q;
  logic [3:0]       cnt_next;
  logic [4:0]       ctrl_dec;
  logic             alu_done;

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign cnt_next  = cnt_q + 4'd1;
  assign alu_done  = alu_finished | alu_err_overflow | alu_err_invalid;

  // Unsupported operations still go to the ALU so it raises its own invalid flag.
  always_comb begin
    ctrl_dec = CtrlInvalid;
    case (in_alu_op)
      2'b00: ctrl_dec = 5'h2;
      2'b01: ctrl_dec = 5'h6;
      2'b10: begin
        case (in_funct)
          6'b100000: ctrl_dec = 5'h2;
          6'b100001: ctrl_dec = 5'h3;
          6'b100010: ctrl_dec = 5'h6;
          6'b100100: ctrl_dec = 5'h0;
          6'b100101: ctrl_dec = 5'h1;
          6'b100111: ctrl_dec = 5'hC;
          6'b101010: ctrl_dec = 5'h7;
          default:   ctrl_dec = CtrlInvalid;
        endcase
      end
      default: ctrl_dec = CtrlInvalid;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= StIdle;
      cnt_q            <= 4'd0;
      alu_start        <= 1'b0;
      alu_a            <= 32'd0;
      alu_b            <= 32'd0;
      alu_control      <= 5'd0;
      out_result       <= 32'd0;
      out_zero         <= 1'b0;
      out_cout         <= 1'b0;
      out_exc_overflow <= 1'b0;
      out_exc_invalid  <= 1'b0;
      out_exc_timeout  <= 1'b0;
      out_tag          <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          alu_start <= 1'b0;
          if (in_valid) begin
            alu_a       <= in_a;
            alu_b       <= in_b;
            alu_control <= ctrl_dec;
            out_tag     <= in_tag;
            state_q     <= StSetup;
          end
        end
        StSetup: begin
          alu_start <= 1'b1;
          state_q   <= StFire;
        end
        StFire: begin
          alu_start <= 1'b0;
          cnt_q     <= 4'd0;
          state_q   <= StWait;
        end
        StWait: begin
          alu_start <= 1'b0;
          if (alu_done) begin
            out_exc_timeout <= 1'b0;
            if (alu_err_invalid) begin
              out_result       <= 32'd0;
              out_zero         <= 1'b0;
              out_cout         <= 1'b0;
              out_exc_overflow <= 1'b0;
              out_exc_invalid  <= 1'b1;
            end else begin
              // Overflow (incl. SUB, which reports it with finished low) keeps the raw result.
              out_result       <= alu_result;
              out_zero         <= alu_zero;
              out_cout         <= alu_cout;
              out_exc_overflow <= alu_err_overflow;
              out_exc_invalid  <= 1'b0;
            end
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_next;
            if (cnt_next == TimeoutCnt) begin
              out_result       <= 32'd0;
              out_zero         <= 1'b0;
              out_cout         <= 1'b0;
              out_exc_overflow <= 1'b0;
              out_exc_invalid  <= 1'b0;
              out_exc_timeout  <= 1'b1;
              state_q          <= StDone;
            end
          end
        end
        StDone: begin
          alu_start <= 1'b0;
          if (out_ready) state_q <= StIdle;
        end
        default: begin
          alu_start <= 1'b0;
          state_q   <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural stand-in for alu_32.
module tb_alu_issue_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic [1:0]  in_alu_op = '0;
  logic [5:0]  in_funct = '0;
  logic [4:0]  in_tag = '0;
  logic        alu_start;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [4:0]  alu_control;
  logic        alu_finished = 1'b0;
  logic [31:0] alu_result = '0;
  logic        alu_zero = 1'b0;
  logic        alu_cout = 1'b0;
  logic        alu_err_overflow = 1'b0;
  logic        alu_err_invalid = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
  logic        out_zero;
  logic        out_cout;
  logic        out_exc_overflow;
  logic        out_exc_invalid;
  logic        out_exc_timeout;
  logic [4:0]  out_tag;

  int n_tests = 0;
  int n_fail  = 0;
  int start_cnt = 0;
  logic silent = 1'b0;

  alu_issue_ctrl #(.TAG_W(5), .TIMEOUT(4)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_alu_op(in_alu_op), .in_funct(in_funct), .in_tag(in_tag),
    .alu_start(alu_start), .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .alu_finished(alu_finished), .alu_result(alu_result), .alu_zero(alu_zero),
    .alu_cout(alu_cout), .alu_err_overflow(alu_err_overflow),
    .alu_err_invalid(alu_err_invalid),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero), .out_cout(out_cout), .out_exc_overflow(out_exc_overflow),
    .out_exc_invalid(out_exc_invalid), .out_exc_timeout(out_exc_timeout), .out_tag(out_tag)
  );

  always #5 clock = ~clock;

  // ALU stand-in: responds one edge after the start pulse; flags stay up until the next start.
  logic [32:0] sum;
  logic        ovf;
  always_comb begin
    sum = '0;
    ovf = 1'b0;
    case (alu_control)
      5'h0: sum = {1'b0, alu_a & alu_b};
      5'h1: sum = {1'b0, alu_a | alu_b};
      5'h2, 5'h3: sum = {1'b0, alu_a} + {1'b0, alu_b};
      5'h6: sum = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
      5'h7: sum = {32'd0, $signed(alu_a) < $signed(alu_b)};
      5'hC: sum = {1'b0, ~(alu_a | alu_b)};
      default: sum = '0;
    endcase
    if (alu_control == 5'h2) ovf = (alu_a[31] == alu_b[31]) && (sum[31] != alu_a[31]);
    if (alu_control == 5'h6) ovf = (alu_a[31] != alu_b[31]) && (sum[31] != alu_a[31]);
  end

  always @(posedge clock) begin
    if (alu_start) begin
      start_cnt <= start_cnt + 1;
      if (silent) begin
        alu_finished <= 1'b0; alu_err_overflow <= 1'b0; alu_err_invalid <= 1'b0;
      end else if (alu_control == 5'h1F) begin
        alu_finished <= 1'b0; alu_err_overflow <= 1'b0; alu_err_invalid <= 1'b1;
        alu_result <= 32'hDEADBEEF; alu_zero <= 1'b1; alu_cout <= 1'b1;
      end else begin
        alu_result <= sum[31:0]; alu_zero <= (sum[31:0] == 32'd0); alu_cout <= sum[32];
        alu_err_overflow <= ovf; alu_err_invalid <= 1'b0; alu_finished <= !ovf;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Presents one bundle, drops in_valid after the accept edge; returns at the negedge after it.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                       input logic [5:0] fn, input logic [4:0] tag);
    @(negedge clock);
    check_eq("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_a = a; in_b = b; in_alu_op = op; in_funct = fn; in_tag = tag;
    @(negedge clock);
    in_valid = 1'b0;
    start_cnt = 0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clock);
      lat++;
    end
  endtask

  task automatic run_check(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] op, input logic [5:0] fn, input logic [4:0] tag,
                           input logic [4:0] e_ctrl, input logic [31:0] e_res,
                           input logic e_zero, input logic e_cout, input logic e_ovf,
                           input logic e_inv, input logic e_to, input int e_lat);
    int lat;
    issue(a, b, op, fn, tag);
    check_eq({name, "_ctrl"}, 32'(alu_control), 32'(e_ctrl));
    check_eq({name, "_busy"}, 32'(in_ready), 32'd0);
    wait_done(lat);
    check_eq({name, "_lat"}, 32'(lat), 32'(e_lat));
    check_eq({name, "_starts"}, 32'(start_cnt), 32'd1);
    check_eq({name, "_res"}, out_result, e_res);
    check_eq({name, "_flags"}, {27'd0, out_zero, out_cout, out_exc_overflow, out_exc_invalid,
             out_exc_timeout}, {27'd0, e_zero, e_cout, e_ovf, e_inv, e_to});
    check_eq({name, "_tag"}, 32'(out_tag), 32'(tag));
    @(negedge clock);
    check_eq({name, "_back_idle"}, {30'd0, in_ready, out_valid}, 32'd2);
  endtask

  initial begin
    int lat;
    int seen;
    logic [31:0] held;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    check_eq("rst_state", {27'd0, in_ready, out_valid, alu_start, out_exc_timeout,
             out_exc_invalid}, {27'd0, 5'b10000});
    check_eq("rst_ctrl", {27'd0, alu_control}, 32'd0);
    check_eq("rst_res", out_result, 32'd0);

    //        name    a             b             op     funct      tag  ctrl   result
    run_check("add",  32'd5,        32'd7,        2'b10, 6'b100000, 5'd3, 5'h2, 32'd12,
              1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3);
    run_check("beq",  32'h1234,     32'h1234,     2'b01, 6'b000000, 5'd4, 5'h6, 32'd0,
              1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3);
    run_check("subov", 32'h80000000, 32'd1,       2'b01, 6'b000000, 5'd5, 5'h6, 32'h7FFFFFFF,
              1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3);
    run_check("addov", 32'h7FFFFFFF, 32'h7FFFFFFF, 2'b10, 6'b100000, 5'd6, 5'h2, 32'hFFFFFFFE,
              1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3);
    run_check("addu", 32'h7FFFFFFF, 32'h7FFFFFFF, 2'b10, 6'b100001, 5'd7, 5'h3, 32'hFFFFFFFE,
              1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3);
    run_check("badfn", 32'd1,       32'd2,        2'b10, 6'b001000, 5'd8, 5'h1F, 32'd0,
              1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3);
    run_check("op11", 32'd1,        32'd2,        2'b11, 6'b100000, 5'd9, 5'h1F, 32'd0,
              1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3);
    run_check("and",  32'h0000F0F0, 32'h0000FF00, 2'b10, 6'b100100, 5'd10, 5'h0, 32'h0000F000,
              1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3);
    run_check("or",   32'h0000F0F0, 32'h0000FF00, 2'b10, 6'b100101, 5'd11, 5'h1, 32'h0000FFF0,
              1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3);
    run_check("nor",  32'd0,        32'd0,        2'b10, 6'b100111, 5'd12, 5'hC, 32'hFFFFFFFF,
              1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3);
    run_check("slt",  32'hFFFFFFFF, 32'd1,        2'b10, 6'b101010, 5'd13, 5'h7, 32'd1,
              1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3);
    run_check("subfn", 32'd9,       32'd4,        2'b10, 6'b100010, 5'd14, 5'h6, 32'd5,
              1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3);
    run_check("lw",   32'h100,      32'h20,       2'b00, 6'b111111, 5'd15, 5'h2, 32'h120,
              1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3);

    // Backpressure: result must hold and new bundles are ignored while out_ready is low.
    out_ready = 1'b0;
    issue(32'd20, 32'd22, 2'b10, 6'b100000, 5'd17);
    wait_done(lat);
    check_eq("bp_lat", 32'(lat), 32'd3);
    in_valid = 1'b1; in_a = 32'hAAAA0000; in_b = 32'd1; in_alu_op = 2'b00; in_tag = 5'd30;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check_eq("bp_hold", {29'd0, out_valid, in_ready, out_exc_overflow}, 32'd4);
      check_eq("bp_res", out_result, 32'd42);
      check_eq("bp_tag", 32'(out_tag), 32'd17);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clock);
    check_eq("bp_release", {30'd0, in_ready, out_valid}, 32'd2);
    check_eq("bp_a_kept", alu_a, 32'd20);
    run_check("bp_next", 32'd3, 32'd4, 2'b00, 6'b000000, 5'd18, 5'h2, 32'd7,
              1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3);

    // Silent ALU: timeout after 4 WAIT cycles, even with a stale finished still high.
    silent = 1'b1;
    run_check("tmo", 32'd1, 32'd1, 2'b00, 6'b000000, 5'd19, 5'h2, 32'd0,
              1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6);

    // Reset while in WAIT drops the operation.
    issue(32'd8, 32'd8, 2'b00, 6'b000000, 5'd20);
    repeat (3) @(negedge clock);
    check_eq("pre_rst_wait", {30'd0, out_valid, in_ready}, 32'd0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_eq("mid_rst", {28'd0, in_ready, out_valid, alu_start, out_exc_timeout}, 32'd8);
    check_eq("mid_rst_ctrl", {27'd0, alu_control}, 32'd0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (out_valid || alu_start) seen++;
    end
    check_eq("mid_rst_quiet", 32'(seen), 32'd0);

    silent = 1'b0;
    run_check("post_rst", 32'd100, 32'd1, 2'b01, 6'b000000, 5'd21, 5'h6, 32'd99,
              1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3);
    held = out_result;
    check_eq("post_rst_hold", held, 32'd99);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
